// File: rtl/ila_trigger_gen.sv
// rtl/ila_trigger_gen.sv - masked-pattern trigger qualifier feeding the ILA capture block
// Optional timeout trigger enabled by defining ILA_TRIG_TIMEOUT_EN.
module ila_trigger_gen #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] probe_in,
  input  logic                  probe_valid,
  input  logic                  arm,
  input  logic                  disarm,
  input  logic [DATA_WIDTH-1:0] cfg_pattern,
  input  logic [DATA_WIDTH-1:0] cfg_mask,
  input  logic [1:0]            cfg_mode,
  input  logic [CNT_WIDTH-1:0]  cfg_match_cnt,
`ifdef ILA_TRIG_TIMEOUT_EN
  input  logic [CNT_WIDTH-1:0]  cfg_timeout,
`endif
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  trigger_out,
  output logic                  timeout_flag,
  output logic [1:0]            state_out,
  output logic [CNT_WIDTH-1:0]  event_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FIRED = 2'b10
  } state_t;

  localparam logic [1:0] MODE_EDGE   = 2'd1;
  localparam logic [1:0] MODE_CONSEC = 2'd2;
  localparam logic [CNT_WIDTH:0] ONE = 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] probe_q, probe_d, dout_q, dout_d;
  logic [DATA_WIDTH-1:0] pattern_q, pattern_d, mask_q, mask_d;
  logic                  vld_q, vld_d, hit_q, hit_d, dvld_q, dvld_d, trig_q, trig_d;
  logic                  last_hit_q, last_hit_d;
  logic [1:0]            mode_q, mode_d;
  logic [CNT_WIDTH-1:0]  match_cnt_q, match_cnt_d, evt_cnt_q, evt_cnt_d;
  logic [CNT_WIDTH:0]    eff_cnt, evt_next;
  logic                  qual;
`ifdef ILA_TRIG_TIMEOUT_EN
  logic                  tflag_q, tflag_d;
  logic [CNT_WIDTH-1:0]  timer_q, timer_d, timeout_q, timeout_d;
  logic [CNT_WIDTH:0]    timer_next;
`endif

  always_comb begin
    probe_d     = probe_in;
    vld_d       = probe_valid;
    hit_d       = probe_valid & (((probe_in ^ pattern_q) & mask_q) == '0);
    dout_d      = probe_q;
    dvld_d      = vld_q;
    trig_d      = 1'b0;
    state_d     = state_q;
    pattern_d   = pattern_q;
    mask_d      = mask_q;
    mode_d      = mode_q;
    match_cnt_d = match_cnt_q;
    evt_cnt_d   = evt_cnt_q;
    last_hit_d  = vld_q ? hit_q : last_hit_q;
    eff_cnt     = (match_cnt_q == '0) ? ONE : {1'b0, match_cnt_q};
    evt_next    = {1'b0, evt_cnt_q} + ONE;
    qual        = vld_q & ((mode_q == MODE_EDGE) ? (hit_q & ~last_hit_q) : hit_q);
`ifdef ILA_TRIG_TIMEOUT_EN
    tflag_d     = tflag_q;
    timer_d     = timer_q;
    timeout_d   = timeout_q;
    timer_next  = {1'b0, timer_q} + ONE;
`endif
    if (disarm) begin
      state_d = ST_IDLE;
    end else if (arm) begin
      state_d     = ST_ARMED;
      pattern_d   = cfg_pattern;
      mask_d      = cfg_mask;
      mode_d      = cfg_mode;
      match_cnt_d = cfg_match_cnt;
      evt_cnt_d   = '0;
      last_hit_d  = 1'b0;
`ifdef ILA_TRIG_TIMEOUT_EN
      tflag_d     = 1'b0;
      timer_d     = '0;
      timeout_d   = cfg_timeout;
`endif
    end else if (state_q == ST_ARMED) begin
      if (qual) begin
        evt_cnt_d = evt_next[CNT_WIDTH] ? evt_cnt_q : evt_next[CNT_WIDTH-1:0];
        if (evt_next >= eff_cnt) begin
          trig_d  = 1'b1;
          state_d = ST_FIRED;
        end
      end else if (vld_q && !hit_q && mode_q == MODE_CONSEC) begin
        evt_cnt_d = '0;
      end
`ifdef ILA_TRIG_TIMEOUT_EN
      timer_d = timer_next[CNT_WIDTH] ? timer_q : timer_next[CNT_WIDTH-1:0];
      // a real match in the same cycle takes precedence over the timeout
      if (!trig_d && timeout_q != '0 && timer_next >= {1'b0, timeout_q}) begin
        trig_d  = 1'b1;
        tflag_d = 1'b1;
        state_d = ST_FIRED;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      probe_q     <= '0;
      vld_q       <= 1'b0;
      hit_q       <= 1'b0;
      dout_q      <= '0;
      dvld_q      <= 1'b0;
      trig_q      <= 1'b0;
      pattern_q   <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      match_cnt_q <= '0;
      evt_cnt_q   <= '0;
      last_hit_q  <= 1'b0;
`ifdef ILA_TRIG_TIMEOUT_EN
      tflag_q     <= 1'b0;
      timer_q     <= '0;
      timeout_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      probe_q     <= probe_d;
      vld_q       <= vld_d;
      hit_q       <= hit_d;
      dout_q      <= dout_d;
      dvld_q      <= dvld_d;
      trig_q      <= trig_d;
      pattern_q   <= pattern_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      match_cnt_q <= match_cnt_d;
      evt_cnt_q   <= evt_cnt_d;
      last_hit_q  <= last_hit_d;
`ifdef ILA_TRIG_TIMEOUT_EN
      tflag_q     <= tflag_d;
      timer_q     <= timer_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign data_out    = dout_q;
  assign data_valid  = dvld_q;
  assign trigger_out = trig_q;
  assign state_out   = state_q;
  assign event_cnt   = evt_cnt_q;
`ifdef ILA_TRIG_TIMEOUT_EN
  assign timeout_flag = tflag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_ila_trigger_gen.sv
// tb/tb_ila_trigger_gen.sv - directed vector table plus randomized model comparison for ila_trigger_gen
module tb_ila_trigger_gen;
  localparam int DW = 64;
  localparam int CW = 8;
  localparam logic [63:0] P = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] N = 64'h0000_0000_0000_1234;
  localparam logic [63:0] Z = 64'h0;

  logic          clk = 1'b0;
  logic          rst_n, probe_valid, arm, disarm;
  logic [DW-1:0] probe_in, cfg_pattern, cfg_mask;
  logic [1:0]    cfg_mode;
  logic [CW-1:0] cfg_match_cnt;
`ifdef ILA_TRIG_TIMEOUT_EN
  logic [CW-1:0] cfg_timeout;
`endif
  logic [DW-1:0] data_out;
  logic          data_valid, trigger_out, timeout_flag;
  logic [1:0]    state_out;
  logic [CW-1:0] event_cnt;

  always #5 clk = ~clk;

  ila_trigger_gen #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .probe_in(probe_in), .probe_valid(probe_valid),
    .arm(arm), .disarm(disarm), .cfg_pattern(cfg_pattern), .cfg_mask(cfg_mask),
    .cfg_mode(cfg_mode), .cfg_match_cnt(cfg_match_cnt),
`ifdef ILA_TRIG_TIMEOUT_EN
    .cfg_timeout(cfg_timeout),
`endif
    .data_out(data_out), .data_valid(data_valid), .trigger_out(trigger_out),
    .timeout_flag(timeout_flag), .state_out(state_out), .event_cnt(event_cnt)
  );

  typedef struct {
    logic        r, a, d, v;
    logic [63:0] p;
    logic [1:0]  m;
    logic [7:0]  c;
    logic        et;
    logic [1:0]  es;
    logic [7:0]  ec;
  } vec_t;
  vec_t vecs[$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, a, d, v, input logic [63:0] p, input logic [1:0] m,
                     input logic [7:0] c, input logic et, input logic [1:0] es, input logic [7:0] ec);
    vec_t t;
    t.r = r; t.a = a; t.d = d; t.v = v; t.p = p; t.m = m; t.c = c;
    t.et = et; t.es = es; t.ec = ec;
    vecs.push_back(t);
  endtask

  // reference model: behaviour from the trigger rules, stage-1 beats held in a queue
  typedef struct packed {logic [63:0] probe; logic valid; logic hit;} beat_t;
  beat_t       pipe[$];
  int          m_st, m_cnt, m_mcnt, m_mode;
  bit          m_last;
  logic [63:0] m_pat, m_mask;
  logic        e_trig, e_dv;
  logic [63:0] e_data;

  task automatic model_step();
    beat_t cur, nb;
    int need;
    bit ev;
    cur = (pipe.size() > 0) ? pipe.pop_front() : '0;
    nb.probe = probe_in;
    nb.valid = probe_valid;
    nb.hit   = probe_valid && (((probe_in ^ m_pat) & m_mask) == 64'h0);
    e_trig = 1'b0;
    if (!rst_n) begin
      m_st = 0; m_cnt = 0; m_mcnt = 0; m_mode = 0; m_last = 0; m_pat = '0; m_mask = '0;
      pipe.delete();
      e_data = '0; e_dv = 1'b0;
      return;
    end
    if (disarm) begin
      m_st = 0;
    end else if (arm) begin
      m_st = 1; m_cnt = 0;
      m_pat = cfg_pattern; m_mask = cfg_mask; m_mode = cfg_mode; m_mcnt = cfg_match_cnt;
    end else if (m_st == 1 && cur.valid) begin
      ev   = (m_mode == 1) ? (cur.hit && !m_last) : cur.hit;
      need = (m_mcnt == 0) ? 1 : m_mcnt;
      if (ev) begin
        if (m_cnt + 1 >= need) begin
          e_trig = 1'b1;
          m_st = 2;
        end
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
      end else if (m_mode == 2 && !cur.hit) begin
        m_cnt = 0;
      end
    end
    if (arm && !disarm) m_last = 0;
    else if (cur.valid) m_last = cur.hit;
    pipe.push_back(nb);
    e_data = cur.probe;
    e_dv   = cur.valid;
  endtask

  initial begin
    logic [64:0] exp_d;
    int fire_at;
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; probe_valid = 1'b0; probe_in = '0;
    cfg_pattern = P; cfg_mask = '1; cfg_mode = 2'd0; cfg_match_cnt = 8'd1;
`ifdef ILA_TRIG_TIMEOUT_EN
    cfg_timeout = '0;
`endif
    fire_at = 0;

    //   r a d v probe m  cnt   et es  ec
    add(0,0,0,0, Z, 0, 1,   0, 0, 0);   // reset
    add(1,0,0,0, Z, 0, 1,   0, 0, 0);
    add(1,1,0,0, Z, 0, 1,   0, 1, 0);   // single match
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,0, Z, 0, 1,   1, 2, 1);
    add(1,0,0,1, P, 0, 1,   0, 2, 1);
    add(1,0,0,0, Z, 0, 1,   0, 2, 1);
    add(1,1,0,0, Z, 0, 3,   0, 1, 0);   // occur x3 with gaps
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,1, N, 0, 1,   0, 1, 1);
    add(1,0,0,0, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,0, N, 0, 1,   0, 1, 2);
    add(1,0,0,1, N, 0, 1,   0, 1, 2);
    add(1,0,0,1, P, 0, 1,   0, 1, 2);
    add(1,0,0,0, Z, 0, 1,   1, 2, 3);
    add(1,0,0,1, P, 0, 1,   0, 2, 3);
    add(1,0,0,0, Z, 0, 1,   0, 2, 3);
    add(1,1,0,0, Z, 2, 4,   0, 1, 0);   // consecutive runs
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 2);
    add(1,0,0,1, N, 0, 1,   0, 1, 3);
    add(1,0,0,0, Z, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 2);
    add(1,0,0,1, P, 0, 1,   0, 1, 3);
    add(1,0,0,0, Z, 0, 1,   1, 2, 4);
    add(1,0,0,0, Z, 0, 1,   0, 2, 4);
    add(1,1,0,0, Z, 1, 2,   0, 1, 0);   // rising edges
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, N, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,0, Z, 0, 1,   1, 2, 2);
    add(1,0,0,0, Z, 0, 1,   0, 2, 2);
    add(1,0,0,0, Z, 0, 1,   0, 2, 2);
    add(1,0,1,0, Z, 0, 1,   0, 0, 2);   // disarm, then arm+disarm together
    add(1,1,1,0, Z, 0, 3,   0, 0, 2);
    add(1,0,0,1, P, 0, 1,   0, 0, 2);
    add(1,0,0,0, Z, 0, 1,   0, 0, 2);
    add(1,1,0,0, Z, 0, 3,   0, 1, 0);   // reset while armed
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 1);
    add(1,0,0,1, P, 0, 1,   0, 1, 2);
    add(0,0,0,0, Z, 0, 1,   0, 0, 0);
    add(1,0,0,0, Z, 0, 1,   0, 0, 0);
    add(1,0,0,1, P, 0, 1,   0, 0, 0);
    add(1,0,0,0, Z, 0, 1,   0, 0, 0);
    add(1,1,0,0, Z, 0, 1,   0, 1, 0);   // disarm on the would-be fire cycle
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,1,0, Z, 0, 1,   0, 0, 0);
    add(1,0,0,0, Z, 0, 1,   0, 0, 0);
    add(1,1,0,0, Z, 3, 0,   0, 1, 0);   // count 0 acts as 1, reserved mode as occur
    add(1,0,0,1, N, 0, 1,   0, 1, 0);
    add(1,0,0,1, P, 0, 1,   0, 1, 0);
    add(1,0,0,0, Z, 0, 1,   1, 2, 1);
    add(1,0,0,0, Z, 0, 1,   0, 2, 1);

    foreach (vecs[i]) begin
      rst_n = vecs[i].r; arm = vecs[i].a; disarm = vecs[i].d;
      probe_valid = vecs[i].v; probe_in = vecs[i].p;
      cfg_mode = vecs[i].m; cfg_match_cnt = vecs[i].c;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d ctl", i), 128'({trigger_out, state_out, event_cnt, timeout_flag}),
          128'({vecs[i].et, vecs[i].es, vecs[i].ec, 1'b0}));
      if (i > 0 && vecs[i].r && vecs[i-1].r) exp_d = {vecs[i-1].v, vecs[i-1].p};
      else exp_d = '0;
      chk($sformatf("row%0d data", i), 128'({data_valid, data_out}), 128'(exp_d));
    end

    // randomized run against the reference model
    for (int i = 0; i < 1500; i++) begin
      rst_n  = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
      arm    = ($urandom_range(0, 11) == 0);
      disarm = ($urandom_range(0, 39) == 0);
      cfg_pattern   = {$urandom, $urandom};
      cfg_mask      = ($urandom_range(0, 7) == 0) ? 64'h0 :
                      ({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom});
      cfg_mode      = 2'($urandom_range(0, 3));
      cfg_match_cnt = 8'($urandom_range(0, 4));
      probe_valid   = ($urandom_range(0, 3) != 0);
      probe_in      = ($urandom_range(0, 1) != 0) ? (m_pat ^ ({$urandom, $urandom} & ~m_mask))
                                                  : {$urandom, $urandom};
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rand%0d ctl", i), 128'({trigger_out, state_out, event_cnt, timeout_flag}),
          128'({e_trig, 2'(m_st), 8'(m_cnt), 1'b0}));
      chk($sformatf("rand%0d data", i), 128'({data_valid, data_out}), 128'({e_dv, e_data}));
    end

`ifdef ILA_TRIG_TIMEOUT_EN
    rst_n = 1'b0; arm = 1'b0; disarm = 1'b0; probe_valid = 1'b0; probe_in = N;
    @(posedge clk); #1;
    rst_n = 1'b1; cfg_pattern = P; cfg_mask = '1; cfg_mode = 2'd0; cfg_match_cnt = 8'd1;
    cfg_timeout = 8'd10; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0; probe_valid = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (trigger_out && fire_at == 0) begin
        fire_at = k;
        chk("timeout flag", 128'(timeout_flag), 128'(1));
        chk("timeout state", 128'(state_out), 128'(2));
      end
    end
    chk("timeout window", 128'(fire_at >= 10 && fire_at <= 12), 128'(1));
    cfg_timeout = 8'd0; probe_valid = 1'b0; arm = 1'b1;
    @(posedge clk); #1;
    arm = 1'b0;
    chk("timeout flag clear", 128'(timeout_flag), 128'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
